// File: rtl/trigger_pkg.sv
// Shared types and constants for the push-button trigger controller.
package trigger_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        RELEASE = 2'd2
    } trig_state_t;

    localparam int PRESS_CNT_W = 8;
endpackage

// File: rtl/btn_debounce.sv
// Synchronises the raw button input and debounces it into a stable level that
// only changes after DEBOUNCE_CYCLES consecutive differing synchronised samples.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic db_level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in};
        sync_out = sync_q[SYNC_STAGES-1];
        cnt_d    = '0;
        db_d     = db_q;
        // The toggle happens on the edge the count would reach DEBOUNCE_CYCLES.
        if (sync_out != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db_level = db_q;
endmodule

// File: rtl/trigger_ctrl.sv
// One-shot trigger per debounced button press, held until software changes a0
// (when ack_en is set) or until HOLD_MAX cycles elapse.
module trigger_ctrl
    import trigger_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_MAX        = 1024,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_in,
    input  logic [DATA_WIDTH-1:0]  a0,
    input  logic                   ack_en,
    output logic                   trigger,
    output logic                   busy,
    output logic                   timeout,
    output logic [PRESS_CNT_W-1:0] press_count
);
    localparam int HOLD_W = $clog2(HOLD_MAX);

    logic                   db_level;
    trig_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0]  snap_q, snap_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [PRESS_CNT_W-1:0] press_q, press_d;
    logic                   timeout_q, timeout_d;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_in),
        .db_level(db_level)
    );

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        hold_d    = hold_q;
        press_d   = press_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (db_level) begin
                    state_d = FIRE;
                    snap_d  = a0;
                    hold_d  = '0;
                    press_d = press_q + 1'b1;
                end
            end
            FIRE: begin
                // Acknowledge has priority over a timeout landing on the same edge.
                if (ack_en && (a0 != snap_q)) begin
                    state_d = RELEASE;
                end else if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!db_level) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            hold_q    <= '0;
            press_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            timeout_q <= timeout_d;
        end
    end

    assign trigger     = (state_q == FIRE);
    assign busy        = (state_q != IDLE);
    assign timeout     = timeout_q;
    assign press_count = press_q;
endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed and randomized bench for trigger_ctrl against a sample-history reference model.
module tb_trigger_ctrl;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn_in;
    logic [DW-1:0] a0;
    logic          ack_en;
    logic          trigger, busy, timeout;
    logic [7:0]    press_count;

    trigger_ctrl #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_MAX(HOLD), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .a0(a0), .ack_en(ack_en),
        .trigger(trigger), .busy(busy), .timeout(timeout), .press_count(press_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    string phase = "init";

    // Reference model: raw and synchronised sample histories plus fire bookkeeping.
    bit          btn_hist[$];
    bit          syn_hist[$];
    bit          db_m;
    bit          firing_m, await_release_m, to_m;
    int          age_m;
    logic [7:0]  pc_m;
    logic [DW-1:0] snap_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s_%s observed=%0h expected=%0h", phase, tag, obs, exp);
    endtask

    task automatic model_reset();
        btn_hist = {};
        syn_hist = {};
        for (int i = 0; i < SYNC; i++) btn_hist.push_back(1'b0);
        db_m = 0; firing_m = 0; await_release_m = 0; to_m = 0; age_m = 0;
        pc_m = 8'd0; snap_m = '0;
    endtask

    task automatic model_step();
        bit s;
        bit db_old;
        bit all_diff;
        db_old = db_m;
        s = btn_hist[btn_hist.size() - SYNC];
        btn_hist.push_back(btn_in);
        if (btn_hist.size() > 16) void'(btn_hist.pop_front());
        to_m = 0;
        if (firing_m) begin
            if (ack_en && (a0 != snap_m)) begin
                firing_m = 0; await_release_m = 1;
            end else if (age_m == HOLD - 1) begin
                firing_m = 0; await_release_m = 1; to_m = 1;
            end else begin
                age_m++;
            end
        end else if (await_release_m) begin
            if (!db_old) await_release_m = 0;
        end else if (db_old) begin
            firing_m = 1; age_m = 0; snap_m = a0; pc_m = pc_m + 8'd1;
        end
        syn_hist.push_back(s);
        if (syn_hist.size() > 16) void'(syn_hist.pop_front());
        if (syn_hist.size() >= DEB) begin
            all_diff = 1;
            for (int i = 1; i <= DEB; i++)
                if (syn_hist[syn_hist.size() - i] == db_m) all_diff = 0;
            if (all_diff) db_m = !db_m;
        end
    endtask

    task automatic check_all();
        chk("trigger", {31'd0, trigger}, {31'd0, firing_m});
        chk("busy", {31'd0, busy}, {31'd0, firing_m | await_release_m});
        chk("timeout", {31'd0, timeout}, {31'd0, to_m});
        chk("press_count", {24'd0, press_count}, {24'd0, pc_m});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // which: 0 -> wait for trigger high, 1 -> wait for busy low. n = maxn+1 on expiry.
    task automatic run_until(input int which, input int maxn, output int n);
        n = maxn + 1;
        for (int i = 1; i <= maxn; i++) begin
            step();
            if ((which == 0 && trigger === 1'b1) || (which == 1 && busy === 1'b0)) begin
                n = i;
                break;
            end
        end
    endtask

    // Called just after a rising edge; asserts reset mid-cycle.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int len;
        logic [7:0] pc_before;
        bit bounce[12];

        rst_n = 1'b0; btn_in = 1'b0; a0 = '0; ack_en = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        phase = "reset";
        check_all();
        rst_n = 1'b1;

        phase = "s1_idle";
        repeat (20) step();

        phase = "s2_ack";
        a0 = 32'd0; ack_en = 1'b1; btn_in = 1'b1;
        run_until(0, 20, n);
        chk("latency", n, 7);
        chk("count", {24'd0, press_count}, 32'd1);
        a0 = 32'd5;
        step();
        chk("fall", {31'd0, trigger}, 32'd0);
        btn_in = 1'b0;
        run_until(1, 20, n);
        chk("idle_edges", n, 7);

        phase = "s3_bounce";
        bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            btn_in = bounce[i];
            step();
        end
        repeat (10) step();
        chk("count", {24'd0, press_count}, 32'd1);

        phase = "s4_timeout";
        ack_en = 1'b0; btn_in = 1'b1;
        run_until(0, 20, n);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (trigger === 1'b1) cnt++;
            else break;
        end
        chk("high_cycles", cnt, HOLD);
        chk("pulse", {31'd0, timeout}, 32'd1);
        step();
        chk("pulse_end", {31'd0, timeout}, 32'd0);
        chk("count", {24'd0, press_count}, 32'd2);
        btn_in = 1'b0;
        run_until(1, 20, n);

        phase = "s5_repress";
        ack_en = 1'b1; btn_in = 1'b1;
        run_until(0, 20, n);
        a0 = a0 + 32'd1;
        repeat (50) step();
        chk("no_refire", {24'd0, press_count}, 32'd3);
        btn_in = 1'b0;
        run_until(1, 20, n);
        btn_in = 1'b1;
        run_until(0, 20, n);
        chk("second_fire", {24'd0, press_count}, 32'd4);

        phase = "s6_reset";
        async_reset();
        chk("trigger_low", {31'd0, trigger}, 32'd0);
        run_until(0, 20, n);
        chk("latency", n, 7);
        chk("count", {24'd0, press_count}, 32'd1);
        a0 = a0 + 32'd1;
        step();
        btn_in = 1'b0;
        run_until(1, 20, n);

        phase = "random";
        for (int seg = 0; seg < 90; seg++) begin
            btn_in = 1'($urandom_range(0, 1));
            ack_en = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) a0 = $urandom;
                step();
            end
            if (seg == 45) async_reset();
        end

        phase = "wrap";
        btn_in = 1'b0; ack_en = 1'b1;
        repeat (12) step();
        pc_before = pc_m;
        for (int f = 0; f < 256; f++) begin
            btn_in = 1'b1;
            run_until(0, 20, n);
            a0 = a0 + 32'd1;
            step();
            btn_in = 1'b0;
            run_until(1, 20, n);
        end
        chk("count_wrapped", {24'd0, press_count}, {24'd0, pc_before});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/trigger_ctrl.md
Name: trigger_ctrl

Overview:
- Produces the `trigger` level that the register file writes into x5 every cycle, so software can poll it.
- Synchronises and debounces an asynchronous push-button input.
- Fires one trigger per press and holds it high until software acknowledges or a timeout expires.
- Software acknowledges by changing a0, which the block reads back from the register file's a0 output.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the btn_in synchroniser (min 2).
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to change the debounced level (min 2).
- HOLD_MAX, 1024, maximum cycles trigger stays high without acknowledge (min 2).
- DATA_WIDTH, 32, width of a0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- btn_in  input  1  raw asynchronous button level, active-high.
- a0  input  DATA_WIDTH  register x10 value from the register file.
- ack_en  input  1  when 1, a change of a0 acknowledges a fire; when 0, only the timeout ends a fire.
- trigger  output  1  level driven into register x5.
- busy  output  1  high whenever the FSM is not in IDLE.
- timeout  output  1  one-cycle pulse when a fire ends by timeout.
- press_count  output  8  number of fires since reset; wraps 255 -> 0.

Behaviour:
- Reset: async assert of rst_n forces trigger=0, busy=0, timeout=0, press_count=0, state=IDLE, debounced level=0, and clears all sync, debounce and hold counters. This applies mid-operation as well: trigger drops without waiting for a clock edge.
- Synchroniser: btn_in passes through SYNC_STAGES flops to give sync_out. Nothing else samples btn_in.
- Debounce:
  - A counter increments each cycle that sync_out != db_level, and clears on any cycle where they are equal.
  - db_level toggles, and the counter clears, on the edge where the counter would reach DEBOUNCE_CYCLES.
  - So db_level changes only after DEBOUNCE_CYCLES consecutive differing samples.
- FSM states:
  - IDLE: trigger=0. When db_level=1, go to FIRE. On that edge, snapshot a0 into snap, clear the hold counter, and increment press_count.
  - FIRE: trigger=1 and the hold counter increments each cycle. Exit conditions:
    - ack_en=1 and a0 != snap: go to RELEASE (acknowledge).
    - Otherwise, hold counter == HOLD_MAX-1: go to RELEASE and assert timeout for exactly the following cycle.
  - RELEASE: trigger=0. When db_level=0, go to IDLE. Re-arming requires the button to be released.
- Outputs trigger and busy are decoded directly from registered state.
- Latency: a clean btn_in rise sampled at edge k gives trigger=1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- Trigger duration: on ack, trigger falls at the edge that samples a0 != snap. On timeout, trigger is high for exactly HOLD_MAX cycles.
- Simultaneous ack and timeout in the same cycle: ack wins and timeout is not pulsed.
- Button released during FIRE: fire is unaffected. RELEASE then moves to IDLE on the next edge.
- Re-press during FIRE or RELEASE: no second fire and no press_count change.
- a0 changing while ack_en=0: ignored. Raising ack_en later with a0 != snap acknowledges on that edge.
- press_count increment from 255 wraps to 0 and raises no flag.
- Widths:
  - Debounce counter: $clog2(DEBOUNCE_CYCLES+1) bits.
  - Hold counter: $clog2(HOLD_MAX) bits; must not overflow before the compare.
- Timing relative to the register file: the register file writes on the falling edge, so a0 is stable at the rising edge and no extra a0 synchronisation is needed.

Decomposition:
- Package trigger_pkg holds:
  - typedef enum trig_state_t {IDLE, FIRE, RELEASE}, 2-bit encoding;
  - localparam PRESS_CNT_W = 8.
- One sub-module, btn_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, rst_n, btn_in, db_level), containing the synchroniser and the debounce counter.
- The FSM, snapshot, hold counter and press counter stay in trigger_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_MAX=8, SYNC_STAGES=2.
1. Reset release, then btn_in=0 for 20 cycles -> trigger=0, busy=0, timeout=0, press_count=0 throughout.
2. btn_in rises before edge k, a0=0, ack_en=1 -> trigger=1 after edge k+6 and press_count=1. Drive a0=5 -> trigger=0 at the next edge. Release btn_in -> busy=0 within 7 edges.
3. btn_in bounces with high pulses of 1, 2 and 3 cycles separated by low pulses of 1 cycle, then held low -> trigger never asserts and press_count stays 0.
4. ack_en=0, a0 constant, clean press -> trigger high for exactly 8 cycles, timeout high for exactly 1 cycle after it falls, press_count=1.
5. Press acknowledged while btn_in is still held high for 50 cycles -> no re-fire. Then release and press again -> second fire, press_count=2.
6. Assert rst_n=0 mid-FIRE, between clock edges -> trigger and busy drop immediately and press_count=0. After reset is released with btn_in still high -> a new fire follows after normal latency.
